fd_issue_stage: RTL and testbench
=================================

// Module: fd_issue_stage
// PURPOSE
//   Request-buffering issue stage directly upstream of the fast divider.
//   - Accepts tagged divide requests on a valid/ready port and queues them in a DEPTH-entry FIFO.
//   - Issues one request at a time to the divider via a start pulse, then waits for its done pulse.
//   - Presents quotient/remainder/tag on a valid/ready result port.
// PARAMETERS
//   WIDTH  16  operand / result width, equal to divider WIDTH
//   DEPTH  4   request FIFO entries (power of 2, >=2)
//   TAG_W  4   request tag width, returned unchanged with the result
// PORTS
//   clk                in   1             single clock, rising edge
//   rst                in   1             synchronous, active-high reset
//   req_valid_in       in   1             request valid
//   req_ready_out      out  1             request accepted when valid&&ready
//   req_tag_in         in   TAG_W         request tag
//   req_dividend_in    in   WIDTH         dividend
//   req_divisor_in     in   WIDTH         divisor
//   fd_start_out       out  1             1-cycle start pulse to divider
//   fd_dividend_out    out  WIDTH         operand held stable from start until done
//   fd_divisor_out     out  WIDTH         operand held stable from start until done
//   fd_done_in         in   1             1-cycle done pulse from divider
//   fd_quotient_in     in   WIDTH         valid in the fd_done_in cycle
//   fd_remainder_in    in   WIDTH         valid in the fd_done_in cycle
//   res_valid_out      out  1             result valid
//   res_ready_in       in   1             result consumed when valid&&ready
//   res_tag_out        out  TAG_W         tag of the result
//   res_quotient_out   out  WIDTH         quotient
//   res_remainder_out  out  WIDTH         remainder
//   res_dbz_out        out  1             divide-by-zero flag (see CONFIGURATION)
//   count_out          out  $clog2(DEPTH+1)  FIFO occupancy
//   err_out            out  1             sticky: fd_done_in seen outside WAIT
// BEHAVIOUR
//   Reset: FIFO emptied; state=IDLE; all outputs 0, except req_ready_out=1 the cycle after rst drops.
//     Divider shares rst, so an in-flight operation is abandoned and never reported.
//   FIFO
//   - req_ready_out = (count_out != DEPTH); no bypass of a full FIFO.
//   - Push on accept; pop only in ISSUE; push and pop in one cycle keep count unchanged.
//   - Pointers wrap modulo DEPTH.
//   FSM (registered state)
//   - IDLE: count_out!=0 -> ISSUE.
//   - ISSUE: latch FIFO head into op regs; fd_start_out=1 for exactly this cycle; pop -> WAIT.
//   - WAIT: fd_done_in -> capture quotient/remainder/tag into result regs -> RESP.
//   - RESP: res_valid_out=1, result held stable.
//     - res_ready_in=1 and FIFO non-empty -> ISSUE.
//     - res_ready_in=1 and FIFO empty -> IDLE.
//     - Else stay in RESP.
//   Latency
//   - Request accepted at edge N into an empty FIFO while IDLE: ISSUE (fd_start_out=1) in cycle N+2.
//   - fd_done_in in cycle M: res_valid_out=1 from cycle M+1.
//   - Back-to-back: RESP handshake at edge K, next start in cycle K+1.
//   fd_dividend_out / fd_divisor_out are driven from the op regs and stable from ISSUE through the done cycle.
//   fd_done_in in IDLE/ISSUE/RESP: ignored for data; sets err_out (cleared only by rst).
//   Arithmetic: no width growth; divider results are passed through unmodified.
//   res_* outputs change only on entry to RESP.
// CONFIGURATION
//   FD_DBZ_BYPASS_EN defined:
//   - In ISSUE, if the head divisor==0: no start pulse; pop; go directly to RESP.
//   - Result: quotient={WIDTH{1'b1}}, remainder=dividend, res_dbz_out=1.
//   FD_DBZ_BYPASS_EN undefined:
//   - Zero divisors are issued to the divider like any other request.
//   - res_dbz_out tied 0.
// STRUCTURE
//   Package fd_pkg:
//   - WIDTH default.
//   - typedef enum {IDLE,ISSUE,WAIT,RESP} fd_issue_state_t.
//   - typedef struct packed {tag,dividend,divisor} fd_req_t.
//   Sub-module fd_req_fifo (fd_req_t entries, DEPTH, count output).
//   The FSM and result registers stay in fd_issue_stage.
// TESTING
//   1) Single request tag=3, 100/7, divider model done after 5 cycles -> one start pulse; res q=14 r=2 tag=3; res_valid held until ready.
//   2) Push 5 requests with res_ready_in=0 -> req_ready_out=0 after 4th accept, count_out=4; release ready -> all 5 results in order, one start per request.
//   3) Divisor=0, dividend=0x1234: with macro -> no start, q=0xFFFF r=0x1234 dbz=1; without -> start issued, dbz=0.
//   4) fd_done_in pulsed while IDLE -> err_out=1 and stays 1; no res_valid_out; cleared by rst.
//   5) rst asserted in WAIT with 2 queued -> next cycle count_out=0, res_valid_out=0, fd_start_out=0; no stale result after reset.
//   6) Simultaneous push and RESP->ISSUE pop at count=4 -> count stays 4, req_ready_out stays 0 that cycle.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared types and default sizes for the divider issue stage.
// Holds the FSM state encoding and the queued request record.
// Ports: none (package).
package fd_pkg;

   localparam int FD_WIDTH = 16;   // operand / result width, matches the divider
   localparam int FD_TAG_W = 4;    // request tag width
   localparam int FD_DEPTH = 4;    // request FIFO entries

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } fd_issue_state_t;

   // One queued divide request. The field widths follow the package
   // defaults, so a stage built with other WIDTH/TAG_W must use a matching package.
   typedef struct packed {
      logic [FD_TAG_W-1:0] tag;
      logic [FD_WIDTH-1:0] dividend;
      logic [FD_WIDTH-1:0] divisor;
   } fd_req_t;

endpackage

// File: rtl/fd_issue_stage_if.sv
// Request, divider and result handshake bundle of the divider issue stage.
// Ports: req_* (valid/ready request in), fd_* (start/done divider side), res_* (valid/ready result out).
// slave = issue stage side, master = environment side (request source, divider, result sink).
interface fd_issue_stage_if
   import fd_pkg::*;
#(
   parameter int WIDTH = FD_WIDTH,
   parameter int TAG_W = FD_TAG_W
);
   logic             req_valid_in;
   logic             req_ready_out;
   logic [TAG_W-1:0] req_tag_in;
   logic [WIDTH-1:0] req_dividend_in;
   logic [WIDTH-1:0] req_divisor_in;

   logic             fd_start_out;
   logic [WIDTH-1:0] fd_dividend_out;
   logic [WIDTH-1:0] fd_divisor_out;
   logic             fd_done_in;
   logic [WIDTH-1:0] fd_quotient_in;
   logic [WIDTH-1:0] fd_remainder_in;

   logic             res_valid_out;
   logic             res_ready_in;
   logic [TAG_W-1:0] res_tag_out;
   logic [WIDTH-1:0] res_quotient_out;
   logic [WIDTH-1:0] res_remainder_out;
   logic             res_dbz_out;

   modport slave (
      input  req_valid_in, req_tag_in, req_dividend_in, req_divisor_in,
      output req_ready_out,
      output fd_start_out, fd_dividend_out, fd_divisor_out,
      input  fd_done_in, fd_quotient_in, fd_remainder_in,
      output res_valid_out, res_tag_out, res_quotient_out, res_remainder_out, res_dbz_out,
      input  res_ready_in
   );

   modport master (
      output req_valid_in, req_tag_in, req_dividend_in, req_divisor_in,
      input  req_ready_out,
      input  fd_start_out, fd_dividend_out, fd_divisor_out,
      output fd_done_in, fd_quotient_in, fd_remainder_in,
      input  res_valid_out, res_tag_out, res_quotient_out, res_remainder_out, res_dbz_out,
      output res_ready_in
   );

endinterface

// File: rtl/fd_req_fifo.sv
// Request FIFO: DEPTH entries of fd_req_t, head visible combinationally, occupancy output.
// Latency: a push is visible at the head one cycle later; push and pop in one cycle keep the count.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
// Ports: clk, rst (sync, active-high), i_push/i_push_dat, i_pop, o_head_dat, o_count.
module fd_req_fifo
   import fd_pkg::*;
#(
   parameter int DEPTH = FD_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  fd_req_t                    i_push_dat,
   input  logic                       i_pop,
   output fd_req_t                    o_head_dat,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);

   fd_req_t          r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage carries no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;

endmodule

// File: rtl/fd_issue_stage.sv
// Issue stage in front of the fast divider: queues tagged requests, issues one at a time, returns results.
// Latency: accept at edge N into an empty idle stage -> start in cycle N+2; done in cycle M -> result valid from M+1.
// Backpressure: req_ready_out drops while the FIFO is full; a result is held until res_ready_in.
// Ports: clk, rst (sync, active-high), bus (fd_issue_stage_if.slave), count_out (FIFO occupancy), err_out (sticky stray done).
// Build option FD_DBZ_BYPASS_EN: zero divisors are answered locally (q=all ones, r=dividend, dbz=1) without starting the divider.
module fd_issue_stage
   import fd_pkg::*;
#(
   parameter int WIDTH = FD_WIDTH,
   parameter int TAG_W = FD_TAG_W,
   parameter int DEPTH = FD_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   fd_issue_stage_if.slave            bus,
   output logic [$clog2(DEPTH+1)-1:0] count_out,
   output logic                       err_out
);
   localparam int CNT_W = $clog2(DEPTH+1);

   fd_issue_state_t  r_state;
   fd_issue_state_t  w_state_nxt;
   logic             w_load_op;
   logic [CNT_W-1:0] w_count;
   logic             w_fifo_nempty;
   fd_req_t          w_push_dat;
   fd_req_t          w_head;
   logic             w_req_rdy;
   logic             w_push;
   logic             w_pop;
   logic             w_dbz;
   logic             w_issue_dbz;
   logic             w_done_wait;

   logic [TAG_W-1:0] r_op_tag;
   logic [WIDTH-1:0] r_op_dividend;
   logic [WIDTH-1:0] r_op_divisor;
   logic [TAG_W-1:0] r_res_tag;
   logic [WIDTH-1:0] r_res_quotient;
   logic [WIDTH-1:0] r_res_remainder;
   logic             r_err;

   always_comb begin
      w_push_dat          = '0;
      w_push_dat.tag      = bus.req_tag_in;
      w_push_dat.dividend = bus.req_dividend_in;
      w_push_dat.divisor  = bus.req_divisor_in;
   end

   // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
   assign w_req_rdy     = !rst && (w_count != CNT_W'(DEPTH));
   assign w_push        = bus.req_valid_in && w_req_rdy;
   assign w_pop         = (r_state == ISSUE);
   assign w_fifo_nempty = (w_count != '0);

   fd_req_fifo #(
      .DEPTH (DEPTH)
   ) u_req_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_count    (w_count)
   );

`ifdef FD_DBZ_BYPASS_EN
   assign w_dbz = (r_op_divisor == '0);
`else
   assign w_dbz = 1'b0;
`endif

   assign w_issue_dbz = (r_state == ISSUE) && w_dbz;
   assign w_done_wait = (r_state == WAIT) && bus.fd_done_in;

   // The op registers are loaded on the edge that enters ISSUE, so the
   // operands are already stable in the start cycle and the ISSUE pop
   // only retires the entry that was copied.
   always_comb begin
      w_state_nxt = r_state;
      w_load_op   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fifo_nempty) begin
               w_state_nxt = ISSUE;
               w_load_op   = 1'b1;
            end
         end
         ISSUE: begin
            w_state_nxt = w_dbz ? RESP : WAIT;
         end
         WAIT: begin
            if (bus.fd_done_in) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.res_ready_in) begin
               if (w_fifo_nempty) begin
                  w_state_nxt = ISSUE;
                  w_load_op   = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_op_tag        <= '0;
         r_op_dividend   <= '0;
         r_op_divisor    <= '0;
         r_res_tag       <= '0;
         r_res_quotient  <= '0;
         r_res_remainder <= '0;
         r_err           <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_op) begin
            r_op_tag      <= w_head.tag;
            r_op_dividend <= w_head.dividend;
            r_op_divisor  <= w_head.divisor;
         end
         if (w_issue_dbz) begin
            r_res_tag       <= r_op_tag;
            r_res_quotient  <= '1;
            r_res_remainder <= r_op_dividend;
         end else if (w_done_wait) begin
            r_res_tag       <= r_op_tag;
            r_res_quotient  <= bus.fd_quotient_in;
            r_res_remainder <= bus.fd_remainder_in;
         end
         // A done pulse with no operation outstanding points at a divider/stage mismatch.
         if (bus.fd_done_in && (r_state != WAIT)) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef FD_DBZ_BYPASS_EN
   logic r_res_dbz;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_dbz <= 1'b0;
      end else if (w_issue_dbz) begin
         r_res_dbz <= 1'b1;
      end else if (w_done_wait) begin
         r_res_dbz <= 1'b0;
      end
   end

   assign bus.res_dbz_out = r_res_dbz;
`else
   assign bus.res_dbz_out = 1'b0;
`endif

   assign bus.req_ready_out     = w_req_rdy;
   assign bus.fd_start_out      = (r_state == ISSUE) && !w_dbz;
   assign bus.fd_dividend_out   = r_op_dividend;
   assign bus.fd_divisor_out    = r_op_divisor;
   assign bus.res_valid_out     = (r_state == RESP);
   assign bus.res_tag_out       = r_res_tag;
   assign bus.res_quotient_out  = r_res_quotient;
   assign bus.res_remainder_out = r_res_remainder;
   assign count_out             = w_count;
   assign err_out               = r_err;

endmodule

// File: tb/tb_fd_issue_stage.sv
module tb_fd_issue_stage;
   import fd_pkg::*;

   localparam int W   = 16;
   localparam int TW  = 4;
   localparam int D   = 4;
   localparam int DLY = 5;
`ifdef FD_DBZ_BYPASS_EN
   localparam bit DBZ_EXP = 1'b1;
`else
   localparam bit DBZ_EXP = 1'b0;
`endif

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  q;
      logic [W-1:0]  r;
      logic          dbz;
   } vec_t;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [W-1:0]  q;
      logic [W-1:0]  r;
      logic          dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [$clog2(D+1)-1:0] count_out;
   logic err_out;

   always #5 clk = ~clk;

   fd_issue_stage_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   fd_issue_stage #(.WIDTH(W), .TAG_W(TW), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .count_out (count_out),
      .err_out   (err_out)
   );

   int   checks = 0;
   int   failures = 0;
   int   n_starts = 0;
   exp_t sb[$];
   vec_t tv[11];

   // divider model
   logic          m_done = 1'b0;
   logic          man_done = 1'b0;
   logic [W-1:0]  m_q = '0;
   logic [W-1:0]  m_r = '0;
   logic          m_busy = 1'b0;
   int            m_cnt = 0;
   logic [W-1:0]  m_a, m_b;

   assign bus.fd_done_in      = m_done | man_done;
   assign bus.fd_quotient_in  = m_q;
   assign bus.fd_remainder_in = m_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [TW-1:0] tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
      vec_t v;
      v.tag = tag; v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
      return v;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         m_done = 1'b0;
         if (rst) begin
            m_busy = 1'b0;
         end else if (m_busy) begin
            if (m_cnt == 1) begin
               m_done = 1'b1;
               if (m_b == '0) begin
                  m_q = '1;
                  m_r = m_a;
               end else begin
                  m_q = m_a / m_b;
                  m_r = m_a % m_b;
               end
               m_busy = 1'b0;
            end else begin
               m_cnt--;
            end
         end else if (bus.fd_start_out) begin
            m_busy = 1'b1;
            m_cnt  = DLY;
            m_a    = bus.fd_dividend_out;
            m_b    = bus.fd_divisor_out;
            n_starts++;
         end
      end
   end

   // result monitor / scoreboard
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.res_valid_out && bus.res_ready_in) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got tag %0h with no request outstanding", bus.res_tag_out);
            end else begin
               mon_e = sb.pop_front();
               chk("res_tag", 32'(bus.res_tag_out), 32'(mon_e.tag));
               chk("res_quotient", 32'(bus.res_quotient_out), 32'(mon_e.q));
               chk("res_remainder", 32'(bus.res_remainder_out), 32'(mon_e.r));
               chk("res_dbz", 32'(bus.res_dbz_out), 32'(mon_e.dbz));
            end
         end
      end
   end

   task automatic send(input vec_t v);
      bit acc = 1'b0;
      bus.req_valid_in    = 1'b1;
      bus.req_tag_in      = v.tag;
      bus.req_dividend_in = v.a;
      bus.req_divisor_in  = v.b;
      for (int i = 0; i < 300 && !acc; i++) begin
         @(negedge clk);
         if (bus.req_ready_out) begin
            acc = 1'b1;
            sb.push_back({v.tag, v.q, v.r, v.dbz});
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid_in = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: tag %0h never accepted", v.tag);
      end
   endtask

   task automatic wait_drain(input int max, input string name);
      int i = 0;
      while (sb.size() != 0 && i < max) begin
         @(negedge clk);
         i++;
      end
      @(posedge clk);
      #1;
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_res_valid(input int max, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         seen = bus.res_valid_out;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen_valid;
      rst = 1'b1;
      bus.req_valid_in = 1'b0; bus.req_tag_in = '0; bus.req_dividend_in = '0; bus.req_divisor_in = '0;
      bus.res_ready_in = 1'b0;

      tv[0]  = mk(4'd3,  16'd100,   16'd7,   16'd14,    16'd2,   1'b0);
      tv[1]  = mk(4'd1,  16'd1000,  16'd10,  16'd100,   16'd0,   1'b0);
      tv[2]  = mk(4'd2,  16'd65535, 16'd256, 16'd255,   16'd255, 1'b0);
      tv[3]  = mk(4'd4,  16'd12345, 16'd100, 16'd123,   16'd45,  1'b0);
      tv[4]  = mk(4'd5,  16'd7,     16'd9,   16'd0,     16'd7,   1'b0);
      tv[5]  = mk(4'd6,  16'd50000, 16'd3,   16'd16666, 16'd2,   1'b0);
      tv[6]  = mk(4'd7,  16'hABCD,  16'd1,   16'hABCD,  16'd0,   1'b0);
      tv[7]  = mk(4'd9,  16'h1234,  16'd0,   16'hFFFF,  16'h1234, DBZ_EXP);
      tv[8]  = mk(4'd8,  16'd20,    16'd3,   16'd6,     16'd2,   1'b0);
      tv[9]  = mk(4'd10, 16'd21,    16'd4,   16'd5,     16'd1,   1'b0);
      tv[10] = mk(4'd11, 16'd22,    16'd5,   16'd4,     16'd2,   1'b0);

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready_out), 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid_out), 32'd0);
      chk("rst_start", 32'(bus.fd_start_out), 32'd0);
      chk("rst_err", 32'(err_out), 32'd0);
      chk("rst_res_q", 32'(bus.res_quotient_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.req_ready_out), 32'd1);
      @(posedge clk); #1;

      // single request, latency, result held until ready
      send(tv[0]);
      @(negedge clk);
      chk("start_cycle_n1", 32'(bus.fd_start_out), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("start_cycle_n2", 32'(bus.fd_start_out), 32'd1);
      chk("op_dividend", 32'(bus.fd_dividend_out), 32'd100);
      chk("op_divisor", 32'(bus.fd_divisor_out), 32'd7);
      wait_res_valid(30, "t1_res_valid");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_valid_held", 32'(bus.res_valid_out), 32'd1);
         chk("t1_q_held", 32'(bus.res_quotient_out), 32'd14);
      end
      @(posedge clk); #1;
      bus.res_ready_in = 1'b1;
      wait_drain(10, "t1_drain");
      bus.res_ready_in = 1'b0;
      chk("t1_starts", 32'(n_starts), 32'd1);

      // fill the FIFO while the result port stalls
      for (int i = 1; i <= 5; i++) send(tv[i]);
      wait_res_valid(30, "t2_res_valid");
      chk("t2_count_full", 32'(count_out), 32'd4);
      chk("t2_ready_full", 32'(bus.req_ready_out), 32'd0);
      chk("t2_starts", 32'(n_starts), 32'd2);

      // RESP->ISSUE at count=4 while a request is offered
      @(posedge clk); #1;
      bus.req_valid_in = 1'b1;
      bus.req_tag_in = 4'hF; bus.req_dividend_in = 16'd1; bus.req_divisor_in = 16'd1;
      bus.res_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.res_ready_in = 1'b0;
      @(negedge clk);
      chk("t6_issue_count", 32'(count_out), 32'd4);
      chk("t6_issue_ready", 32'(bus.req_ready_out), 32'd0);
      chk("t6_issue_start", 32'(bus.fd_start_out), 32'd1);
      @(posedge clk); #1;
      bus.req_valid_in = 1'b0;
      @(negedge clk);
      chk("t6_after_pop_count", 32'(count_out), 32'd3);
      @(posedge clk); #1;
      send(tv[6]);
      bus.res_ready_in = 1'b1;
      wait_drain(300, "t2_drain");
      chk("t2_total_starts", 32'(n_starts), 32'd7);

      // zero divisor
      send(tv[7]);
      wait_drain(40, "t3_drain");
      chk("t3_starts", 32'(n_starts), DBZ_EXP ? 32'd7 : 32'd8);

      // stray done while idle
      man_done = 1'b1;
      @(posedge clk); #1;
      man_done = 1'b0;
      @(negedge clk);
      chk("t4_err_set", 32'(err_out), 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.res_valid_out) seen_valid = 1'b1;
      end
      chk("t4_no_result", 32'(seen_valid), 32'd0);
      chk("t4_err_sticky", 32'(err_out), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t4_err_cleared", 32'(err_out), 32'd0);
      @(posedge clk); #1;

      // reset while WAIT with two queued
      bus.res_ready_in = 1'b0;
      send(tv[8]);
      send(tv[9]);
      send(tv[10]);
      @(negedge clk);
      chk("t5_count_before", 32'(count_out), 32'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_count_after", 32'(count_out), 32'd0);
      chk("t5_res_valid_after", 32'(bus.res_valid_out), 32'd0);
      chk("t5_start_after", 32'(bus.fd_start_out), 32'd0);
      bus.res_ready_in = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.res_valid_out) seen_valid = 1'b1;
      end
      chk("t5_no_stale", 32'(seen_valid), 32'd0);
      chk("t5_err", 32'(err_out), 32'd0);
      chk("t5_starts", 32'(n_starts), DBZ_EXP ? 32'd8 : 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
